// File: rtl/block_scheduler.sv
// Frame-paced, interval-shrinking release scheduler for the falling blocks.
// Optional BLOCK_SCHED_LFSR_EN: the release search starts at an LFSR-chosen slot instead of round-robin.
module block_scheduler #(
  parameter int unsigned NUM_BLOCKS   = 5,
  parameter int unsigned SPAWN_FRAMES = 60,
  parameter int unsigned MIN_FRAMES   = 20,
  parameter int unsigned STEP_FRAMES  = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic                  frame_clk,
  input  logic [NUM_BLOCKS-1:0] block_done,
  output logic [NUM_BLOCKS-1:0] block_ready,
  output logic                  busy,
  output logic                  paused,
  output logic [7:0]            spawn_count
);

  localparam int unsigned IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int unsigned FW = 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PAUSE, S_RELEASE} state_t;

  state_t                state, state_d;
  logic                  fs1, fs2, fs3, tick;
  logic                  run_q, run_q2, run_p;
  logic [FW-1:0]         interval, fcnt;
  logic [IW-1:0]         last;
  logic [NUM_BLOCKS-1:0] done_q;

  logic                  load_start, dec_fcnt, do_release;
  logic                  found;
  logic [IW-1:0]         sel;
  logic [NUM_BLOCKS-1:0] set_vec;
  logic signed [8:0]     diff;
  logic [FW-1:0]         interval_nxt;
  int unsigned           start;
  int unsigned           idx;

  // frame strobe synchronizer and Run edge detector
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fs1    <= 1'b0;
      fs2    <= 1'b0;
      fs3    <= 1'b0;
      tick   <= 1'b0;
      run_q  <= 1'b0;
      run_q2 <= 1'b0;
      run_p  <= 1'b0;
    end else begin
      fs1    <= frame_clk;
      fs2    <= fs1;
      fs3    <= fs2;
      tick   <= fs2 & ~fs3;
      run_q  <= Run;
      run_q2 <= run_q;
      run_p  <= run_q & ~run_q2;
    end
  end

`ifdef BLOCK_SCHED_LFSR_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4, stepped once per frame
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lfsr <= 8'hA5;
    end else if (tick) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  always_comb start = 32'(lfsr) % NUM_BLOCKS;
`else
  always_comb start = (32'(last) + 32'd1) % NUM_BLOCKS;
`endif

  // first free slot in circular order; a slot with done pending is never picked
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < int'(NUM_BLOCKS); k++) begin
      idx = (start + 32'(k)) % NUM_BLOCKS;
      if (!found && !block_ready[IW'(idx)] && !block_done[IW'(idx)] && !done_q[IW'(idx)]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  always_comb begin
    diff         = $signed({1'b0, interval}) - $signed(9'(STEP_FRAMES));
    interval_nxt = (diff < $signed(9'(MIN_FRAMES))) ? FW'(MIN_FRAMES) : diff[7:0];
  end

  always_comb begin
    set_vec = '0;
    if (do_release) set_vec[sel] = 1'b1;
  end

  // next-state logic
  always_comb begin
    state_d    = state;
    load_start = 1'b0;
    dec_fcnt   = 1'b0;
    do_release = 1'b0;
    case (state)
      S_IDLE: begin
        if (run_p) begin
          load_start = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (run_p) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          dec_fcnt = 1'b1;
          if (fcnt == FW'(1)) state_d = S_RELEASE;
        end
      end
      S_PAUSE: begin
        if (run_p) state_d = S_WAIT;
      end
      S_RELEASE: begin
        if (found) begin
          do_release = 1'b1;
          state_d    = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      paused <= 1'b0;
    end else begin
      state  <= state_d;
      busy   <= (state_d != S_IDLE);
      paused <= (state_d == S_PAUSE);
    end
  end

  // interval/frame counters, slot bookkeeping; done clears win over a same-cycle set
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      interval    <= FW'(SPAWN_FRAMES);
      fcnt        <= '0;
      last        <= IW'(NUM_BLOCKS - 1);
      spawn_count <= '0;
      done_q      <= '0;
      block_ready <= '0;
    end else begin
      done_q      <= block_done;
      block_ready <= (block_ready | set_vec) & ~done_q;
      if (load_start) begin
        interval <= FW'(SPAWN_FRAMES);
        fcnt     <= FW'(SPAWN_FRAMES);
      end else if (dec_fcnt) begin
        fcnt <= fcnt - FW'(1);
      end else if (do_release) begin
        interval    <= interval_nxt;
        fcnt        <= interval_nxt;
        last        <= sel;
        spawn_count <= spawn_count + 8'd1;
      end
    end
  end

endmodule
